lfsr_rand_server: RTL

//  Owns a single 64-bit maximal-length Fibonacci LFSR and shares it among NREQ requesters.

---
 rtl/lfsr_rand_server.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lfsr_rand_server.sv
// Shared 64-bit Fibonacci LFSR with seed/warm-up sequencing and a
// round-robin draw arbiter. One grant returns the pre-step LFSR word and
// advances the LFSR exactly once.
module lfsr_rand_server #(
  parameter int          NREQ         = 4,
  parameter logic [63:0] SEED_DEFAULT = 64'h7A,
  parameter int          WARMUP       = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            seed_load,
  input  logic [63:0]     seed_val,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            rnd_valid,
  output logic [63:0]     rnd_data,
  output logic            busy,
  output logic            zero_seed,
  output logic [31:0]     draw_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_SEED, S_WARM, S_IDLE} state_e;

  state_e            state_q, state_d;
  logic [63:0]       lfsr_q, lfsr_d;
  logic [63:0]       pend_q, pend_d;
  logic [15:0]       warm_q, warm_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              vld_q, vld_d;
  logic [63:0]       data_q, data_d;
  logic              zero_q, zero_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [NREQ-1:0]   req_m;
  logic              pick_vld;
  logic [PW-1:0]     pick_k;
  logic [PW-1:0]     idx;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  // Round-robin pick: first unmasked request at or after rr_q. The bit
  // granted last cycle is masked so a held req is not granted twice.
  always_comb begin
    req_m    = req & ~gnt_q;
    pick_vld = 1'b0;
    pick_k   = '0;
    idx      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_q) + i) % NREQ);
      if (req_m[idx]) begin
        pick_vld = 1'b1;
        pick_k   = idx;
      end
    end
  end

  // Sequencer: seed load, optional warm-up, then grant draws in IDLE.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    pend_d  = pend_q;
    warm_d  = warm_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    vld_d   = 1'b0;
    data_d  = data_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_SEED: begin
        if (pend_q == 64'd0) begin
          lfsr_d = SEED_DEFAULT;
          zero_d = 1'b1;
        end else begin
          lfsr_d = pend_q;
          zero_d = 1'b0;
        end
        cnt_d   = '0;
        warm_d  = 16'(WARMUP);
        state_d = (WARMUP > 0) ? S_WARM : S_IDLE;
        if (seed_load) begin
          pend_d  = seed_val;
          state_d = S_SEED;
        end
      end
      S_WARM: begin
        lfsr_d = lfsr_step(lfsr_q);
        warm_d = warm_q - 16'd1;
        if (warm_q == 16'd1) state_d = S_IDLE;
        if (seed_load) begin
          pend_d  = seed_val;
          state_d = S_SEED;
        end
      end
      S_IDLE: begin
        if (seed_load) begin
          pend_d  = seed_val;
          state_d = S_SEED;
        end else if (pick_vld) begin
          gnt_d[pick_k] = 1'b1;
          vld_d         = 1'b1;
          data_d        = lfsr_q;
          lfsr_d        = lfsr_step(lfsr_q);
          rr_d          = (int'(pick_k) == NREQ - 1) ? '0 : pick_k + PW'(1);
          cnt_d         = cnt_q + 32'd1;
        end
      end
      default: state_d = S_SEED;
    endcase
  end

  // State registers; reset restarts the seed sequence from SEED_DEFAULT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_SEED;
      lfsr_q  <= SEED_DEFAULT;
      pend_q  <= SEED_DEFAULT;
      warm_q  <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pend_q  <= pend_d;
      warm_q  <= warm_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = vld_q;
  assign rnd_data  = data_q;
  assign busy      = (state_q != S_IDLE);
  assign zero_seed = zero_q;
  assign draw_cnt  = cnt_q;

endmodule
